// File: rtl/sfx_sequencer_if.sv
// Game-side event/gamemode inputs and tone-generator outputs of the sfx sequencer.
interface sfx_sequencer_if #(
  parameter int PERIOD_W = 20
) ();
  logic [1:0]          gamemode;
  logic                ev_jump;
  logic                ev_hit;
  logic                ev_over;
  logic [PERIOD_W-1:0] period;
  logic                tone_en;
  logic                busy;
  logic [1:0]          cur_event;

  modport master (
    output gamemode, ev_jump, ev_hit, ev_over,
    input  period, tone_en, busy, cur_event
  );

  modport slave (
    input  gamemode, ev_jump, ev_hit, ev_over,
    output period, tone_en, busy, cur_event
  );
endinterface

// File: rtl/sfx_sequencer.sv
// Priority-arbitrated sound-effect note sequencer; outputs valid one edge after an event pulse.
// No backpressure: lower-priority pulses during playback are dropped, never queued.
module sfx_sequencer #(
  parameter int TICK_CYCLES = 12500000,
  parameter int PERIOD_W    = 20
) (
  input logic             clk,
  input logic             rst,
  sfx_sequencer_if.slave  bus
);
  localparam int TW = $clog2(TICK_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  localparam logic [PERIOD_W-1:0] P_REST = '0;
  localparam logic [PERIOD_W-1:0] P_C4   = PERIOD_W'(381678);
  localparam logic [PERIOD_W-1:0] P_D4   = PERIOD_W'(340530);
  localparam logic [PERIOD_W-1:0] P_E4   = PERIOD_W'(303030);
  localparam logic [PERIOD_W-1:0] P_G4   = PERIOD_W'(255101);
  localparam logic [PERIOD_W-1:0] P_C5   = PERIOD_W'(191204);
  localparam logic [PERIOD_W-1:0] P_G5   = PERIOD_W'(127551);

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  // Note table keyed by {event, index}; unused slots read as a 1-tick rest.
  function automatic logic [PERIOD_W-1:0] note_period(input logic [1:0] ev, input logic [2:0] idx);
    case ({ev, idx})
      5'b01_000: note_period = P_C5;
      5'b01_001: note_period = P_G5;
      5'b10_000: note_period = P_G4;
      5'b10_001: note_period = P_REST;
      5'b10_010: note_period = P_D4;
      5'b11_000: note_period = P_G4;
      5'b11_001: note_period = P_E4;
      5'b11_010: note_period = P_C4;
      5'b11_011: note_period = P_REST;
      5'b11_100: note_period = P_C4;
      default:   note_period = P_REST;
    endcase
  endfunction

  function automatic logic [2:0] note_dur(input logic [1:0] ev, input logic [2:0] idx);
    case ({ev, idx})
      5'b10_010: note_dur = 3'd2;
      5'b11_000: note_dur = 3'd2;
      5'b11_001: note_dur = 3'd2;
      5'b11_010: note_dur = 3'd2;
      5'b11_100: note_dur = 3'd4;
      default:   note_dur = 3'd1;
    endcase
  endfunction

  function automatic logic [2:0] seq_last(input logic [1:0] ev);
    case (ev)
      2'b01:   seq_last = 3'd1;
      2'b10:   seq_last = 3'd2;
      2'b11:   seq_last = 3'd4;
      default: seq_last = 3'd0;
    endcase
  endfunction

  state_t              state_q;
  logic [1:0]          ev_q;
  logic [2:0]          idx_q;
  logic [TW-1:0]       tick_q;
  logic [2:0]          tin_q;
  logic [PERIOD_W-1:0] period_q;
  logic                tone_en_q;
  logic                busy_q;

  logic [1:0]          ev_d;
  logic                start_d;
  logic                note_end_d;
  logic [2:0]          idx_d;
  logic [PERIOD_W-1:0] start_period_d;
  logic [PERIOD_W-1:0] next_period_d;

  always_comb begin
    ev_d = 2'b00;
    if (bus.ev_over)      ev_d = 2'b11;
    else if (bus.ev_hit)  ev_d = 2'b10;
    else if (bus.ev_jump) ev_d = 2'b01;
    // Equal priority restarts; ev_q is 00 when idle so any event is accepted then.
    start_d        = (bus.gamemode != 2'b00) && (ev_d != 2'b00) &&
                     ((state_q == S_IDLE) || (ev_d >= ev_q));
    note_end_d     = (tick_q == TICK_LAST) && (tin_q == note_dur(ev_q, idx_q) - 3'd1);
    idx_d          = idx_q + 3'd1;
    start_period_d = note_period(ev_d, 3'd0);
    next_period_d  = note_period(ev_q, idx_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ev_q      <= 2'b00;
      idx_q     <= 3'd0;
      tick_q    <= '0;
      tin_q     <= 3'd0;
      period_q  <= '0;
      tone_en_q <= 1'b0;
      busy_q    <= 1'b0;
    end else if (start_d) begin
      state_q   <= S_PLAY;
      ev_q      <= ev_d;
      idx_q     <= 3'd0;
      tick_q    <= '0;
      tin_q     <= 3'd0;
      period_q  <= start_period_d;
      tone_en_q <= (start_period_d != '0);
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_PLAY: begin
          if ((bus.gamemode == 2'b00) || (note_end_d && (idx_q == seq_last(ev_q)))) begin
            state_q   <= S_IDLE;
            ev_q      <= 2'b00;
            idx_q     <= 3'd0;
            tick_q    <= '0;
            tin_q     <= 3'd0;
            period_q  <= '0;
            tone_en_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (note_end_d) begin
            idx_q     <= idx_d;
            tick_q    <= '0;
            tin_q     <= 3'd0;
            period_q  <= next_period_d;
            tone_en_q <= (next_period_d != '0);
          end else if (tick_q == TICK_LAST) begin
            tick_q <= '0;
            tin_q  <= tin_q + 3'd1;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.period    = period_q;
  assign bus.tone_en   = tone_en_q;
  assign bus.busy      = busy_q;
  assign bus.cur_event = ev_q;
endmodule
